muldiv_controller: RTL and testbench
====================================

# muldiv_controller

Sequencer for the iterative multiply/divide unit that sits beside the ALU in the multicycle CPU. The main control unit starts an operation with a one-cycle `mult_start` or `div_start` pulse. This block then captures the operands and runs 32 iterations of radix-2 Booth multiplication or restoring division. On completion it pulses `HI_write`/`LO_write` with the results, or it flags `divzero` so the control unit can enter its exception state.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width.
- `CNT_W`, 6, iteration counter width; must hold `WIDTH`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `mult_start` in 1: one-cycle request for signed multiply `a*b`.
- `div_start` in 1: one-cycle request for signed divide `a/b`.
- `a` in WIDTH: operand A (rs); sampled on the accepting edge.
- `b` in WIDTH: operand B (rt); sampled on the accepting edge.
- `hi` out WIDTH: product[63:32], or remainder.
- `lo` out WIDTH: product[31:0], or quotient.
- `HI_write` out 1: one-cycle write strobe for the HI register.
- `LO_write` out 1: one-cycle write strobe for the LO register.
- `busy` out 1: an operation is in progress.
- `done` out 1: one-cycle pulse; `hi`/`lo` valid.
- `divzero` out 1: one-cycle pulse; divide with `b==0` was rejected.

## Operation
- States: IDLE, MULT_RUN, DIV_RUN, DIV_FIX, DONE.
- **Reset:** `reset=1` forces state IDLE and counter 0. All outputs go to 0, including `hi`/`lo`, on that edge. This applies in any state, mid-operation included. No strobe is issued for an aborted operation.
- **IDLE:**
  - `mult_start`: capture `a` and `b`, clear the accumulator and counter, go to MULT_RUN.
  - `div_start` with `b!=0`: capture operand magnitudes and both signs, go to DIV_RUN.
  - `div_start` with `b==0`: `divzero=1` for one cycle, stay in IDLE. `hi`/`lo` unchanged; no write strobe.
  - If both starts are high, multiply wins and `div_start` is dropped.
- **MULT_RUN:** each cycle performs one Booth step on {acc, multiplier, q-1}, then an arithmetic right shift. After step 32 go to DONE.
- **DIV_RUN:** each cycle performs one restoring step on the unsigned magnitudes (shift remainder:quotient left, trial-subtract the divisor, set the quotient bit). After step 32 go to DIV_FIX.
- **DIV_FIX:** negate the quotient if the operand signs differ; negate the remainder if the dividend was negative. Quotient truncates toward zero. Then go to DONE.
- **Arithmetic special case:** 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. This is wrap-around; no exception is raised.
- **DONE:** `hi`/`lo` registers are loaded; `HI_write=LO_write=done=1` for exactly this cycle. Return to IDLE.
- **Busy handling:** `mult_start`/`div_start` are ignored whenever the state is not IDLE.
- **Result hold:** `hi`/`lo` keep the last completed result until the next DONE or reset.

## Timing
- Cycle 0 is the edge that accepts a start.
- `busy=1` from cycle 1 through the DONE cycle inclusive. `busy=0` in IDLE, including the `divzero` cycle.
- Multiply: MULT_RUN covers cycles 1–32; DONE is cycle 33. Latency is 33 cycles.
- Divide: DIV_RUN covers cycles 1–32; DIV_FIX is cycle 33; DONE is cycle 34. Latency is 34 cycles.
- Divide by zero: `divzero` is high during cycle 1 only.
- A new start can be accepted in the cycle after DONE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `cpu_pkg` holds:
  - the state encoding for `muldiv_state_t`;
  - `MULDIV_ITERS = 32`;
  - the HI/LO width constants used by the control unit.
- Sub-module `muldiv_datapath` contains the Booth and restoring-step registers, adder/subtractor, shifter and sign fix-up. It is driven by `load`, `step`, `op` and `fix` from the FSM in `muldiv_controller`.

## Test plan
- **Signed multiply:** `mult_start`, a=7, b=0xFFFFFFFD → cycle 33: `done`, `HI_write`, `LO_write` high; hi=0xFFFFFFFF, lo=0xFFFFFFEB; `busy` high cycles 1–33.
- **Multiply extremes:** a=b=0x80000000 → hi=0x40000000, lo=0x00000000. Also a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0, lo=1.
- **Signed divide:** `div_start`, a=0xFFFFFFF9 (−7), b=2 → cycle 34: lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- **Divide by zero:** prior result hi=0x11, lo=0x22; `div_start`, a=5, b=0 → `divzero` high cycle 1 only; `busy`, `HI_write`, `LO_write` stay 0; hi/lo still 0x11/0x22.
- **Reset mid-operation:** `reset` asserted during MULT_RUN iteration 10 → next cycle all outputs 0, no strobe. A following `mult_start` with a=3, b=4 completes normally: lo=12 at cycle 33.
- **Start arbitration:** `mult_start` during DIV_RUN is ignored and the divide completes unchanged. `mult_start` and `div_start` together with a=6, b=0 → multiply runs, lo=0 at cycle 33, no `divzero`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: multiply/divide sequencer states, iteration count and HI/LO widths.
package cpu_pkg;

    typedef enum logic [2:0] {
        MD_IDLE     = 3'd0,
        MD_MULT_RUN = 3'd1,
        MD_DIV_RUN  = 3'd2,
        MD_DIV_FIX  = 3'd3,
        MD_DONE     = 3'd4
    } muldiv_state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } muldiv_op_t;

    localparam int MULDIV_ITERS = 32;
    localparam int HI_W         = 32;
    localparam int LO_W         = 32;

endpackage

// File: rtl/muldiv_datapath.sv
// Shared shift/add datapath for radix-2 Booth multiply and restoring divide.
// acc holds the product high half or remainder; mq holds the multiplier/product low half or quotient.
module muldiv_datapath
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             fix,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        magnitude = v[WIDTH-1] ? (~v + ONE) : v;
    endfunction

    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] mq_r;
    logic [WIDTH-1:0] opnd_r;
    logic             qm1_r;
    logic             neg_q_r;
    logic             neg_r_r;

    logic [WIDTH:0]   acc_ext_s;
    logic [WIDTH:0]   mcand_ext_s;
    logic [WIDTH:0]   booth_sum_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH+1:0] trial_s;
    logic [WIDTH-1:0] rem_next_s;
    logic             qbit_s;

    // Booth add/subtract, one bit wider so the following arithmetic shift keeps the true sign
    always_comb begin
        acc_ext_s   = {acc_r[WIDTH-1], acc_r};
        mcand_ext_s = {opnd_r[WIDTH-1], opnd_r};
        case ({mq_r[0], qm1_r})
            2'b01:   booth_sum_s = acc_ext_s + mcand_ext_s;
            2'b10:   booth_sum_s = acc_ext_s - mcand_ext_s;
            default: booth_sum_s = acc_ext_s;
        endcase
    end

    // Restoring trial subtraction on unsigned magnitudes
    always_comb begin
        shifted_s = {acc_r, mq_r[WIDTH-1]};
        trial_s   = {1'b0, shifted_s} - {2'b00, opnd_r};
        if (trial_s[WIDTH+1]) begin
            qbit_s     = 1'b0;
            rem_next_s = shifted_s[WIDTH-1:0];
        end else begin
            qbit_s     = 1'b1;
            rem_next_s = trial_s[WIDTH-1:0];
        end
    end

    // Operand capture, per-iteration update and final sign fix-up
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r   <= ZERO;
            mq_r    <= ZERO;
            opnd_r  <= ZERO;
            qm1_r   <= 1'b0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if (load) begin
            acc_r <= ZERO;
            qm1_r <= 1'b0;
            if (op == OP_MUL) begin
                mq_r    <= a;
                opnd_r  <= b;
                neg_q_r <= 1'b0;
                neg_r_r <= 1'b0;
            end else begin
                mq_r    <= magnitude(a);
                opnd_r  <= magnitude(b);
                neg_q_r <= a[WIDTH-1] ^ b[WIDTH-1];
                neg_r_r <= a[WIDTH-1];
            end
        end else if (step) begin
            if (op == OP_MUL) begin
                acc_r <= booth_sum_s[WIDTH:1];
                mq_r  <= {booth_sum_s[0], mq_r[WIDTH-1:1]};
                qm1_r <= mq_r[0];
            end else begin
                acc_r <= rem_next_s;
                mq_r  <= {mq_r[WIDTH-2:0], qbit_s};
            end
        end else if (fix) begin
            if (neg_q_r) begin
                mq_r <= ~mq_r + ONE;
            end
            if (neg_r_r) begin
                acc_r <= ~acc_r + ONE;
            end
        end
    end

    assign res_hi = acc_r;
    assign res_lo = mq_r;

endmodule

// File: rtl/muldiv_controller.sv
// Sequencer for the iterative multiply/divide unit: accepts start pulses, runs the datapath
// for a fixed number of iterations and presents HI/LO results with one-cycle write strobes.
module muldiv_controller
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             HI_write,
    output logic             LO_write,
    output logic             busy,
    output logic             done,
    output logic             divzero
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULDIV_ITERS - 1);

    muldiv_state_t    state_r;
    muldiv_state_t    state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             dz_pend_r;
    logic             dz_pend_next_s;
    logic             load_s;
    logic             step_s;
    logic             fix_s;
    muldiv_op_t       op_s;
    logic [WIDTH-1:0] res_hi_s;
    logic [WIDTH-1:0] res_lo_s;

    // State, iteration counter and divide-by-zero pending flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= MD_IDLE;
            cnt_r     <= CNT_ZERO;
            dz_pend_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            dz_pend_r <= dz_pend_next_s;
        end
    end

    // Next-state and datapath control; multiply wins when both starts arrive together
    always_comb begin
        state_next_s   = state_r;
        cnt_next_s     = cnt_r;
        dz_pend_next_s = 1'b0;
        load_s         = 1'b0;
        step_s         = 1'b0;
        fix_s          = 1'b0;
        op_s           = OP_MUL;
        case (state_r)
            MD_IDLE: begin
                if (mult_start) begin
                    load_s       = 1'b1;
                    op_s         = OP_MUL;
                    cnt_next_s   = CNT_ZERO;
                    state_next_s = MD_MULT_RUN;
                end else if (div_start) begin
                    if (b == {WIDTH{1'b0}}) begin
                        dz_pend_next_s = 1'b1;
                        state_next_s   = MD_IDLE;
                    end else begin
                        load_s       = 1'b1;
                        op_s         = OP_DIV;
                        cnt_next_s   = CNT_ZERO;
                        state_next_s = MD_DIV_RUN;
                    end
                end else begin
                    state_next_s = MD_IDLE;
                end
            end
            MD_MULT_RUN: begin
                step_s     = 1'b1;
                op_s       = OP_MUL;
                cnt_next_s = cnt_r + CNT_ONE;
                if (cnt_r == CNT_LAST) begin
                    cnt_next_s   = CNT_ZERO;
                    state_next_s = MD_DONE;
                end else begin
                    state_next_s = MD_MULT_RUN;
                end
            end
            MD_DIV_RUN: begin
                step_s     = 1'b1;
                op_s       = OP_DIV;
                cnt_next_s = cnt_r + CNT_ONE;
                if (cnt_r == CNT_LAST) begin
                    cnt_next_s   = CNT_ZERO;
                    state_next_s = MD_DIV_FIX;
                end else begin
                    state_next_s = MD_DIV_RUN;
                end
            end
            MD_DIV_FIX: begin
                fix_s        = 1'b1;
                op_s         = OP_DIV;
                state_next_s = MD_DONE;
            end
            MD_DONE: begin
                state_next_s = MD_IDLE;
            end
            default: begin
                cnt_next_s   = CNT_ZERO;
                state_next_s = MD_IDLE;
            end
        endcase
    end

    muldiv_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk    (clk),
        .reset  (reset),
        .load   (load_s),
        .step   (step_s),
        .fix    (fix_s),
        .op     (op_s),
        .a      (a),
        .b      (b),
        .res_hi (res_hi_s),
        .res_lo (res_lo_s)
    );

    // Registered outputs; results are latched only in DONE so they hold until the next completion
    always_ff @(posedge clk) begin
        if (reset) begin
            hi       <= {WIDTH{1'b0}};
            lo       <= {WIDTH{1'b0}};
            HI_write <= 1'b0;
            LO_write <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            divzero  <= 1'b0;
        end else begin
            busy     <= (state_r != MD_IDLE);
            done     <= (state_r == MD_DONE);
            HI_write <= (state_r == MD_DONE);
            LO_write <= (state_r == MD_DONE);
            divzero  <= dz_pend_r;
            if (state_r == MD_DONE) begin
                hi <= res_hi_s;
                lo <= res_lo_s;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_controller.sv
// Self-checking bench for muldiv_controller: directed and random operations against a plain-arithmetic model.
module tb_muldiv_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        mult_start;
    logic        div_start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        HI_write;
    logic        LO_write;
    logic        busy;
    logic        done;
    logic        divzero;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_hi = 32'h0;
    logic [31:0] exp_lo = 32'h0;

    muldiv_controller #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mult_start (mult_start),
        .div_start  (div_start),
        .a          (a),
        .b          (b),
        .hi         (hi),
        .lo         (lo),
        .HI_write   (HI_write),
        .LO_write   (LO_write),
        .busy       (busy),
        .done       (done),
        .divzero    (divzero)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return p;
    endfunction

    // {remainder, quotient}; quotient truncates toward zero, remainder takes the dividend's sign
    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q  = sx / sy;
        r  = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [4:0] status();
        return {busy, done, HI_write, LO_write, divzero};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One operation from start pulse to the cycle after DONE; inject_at>0 fires a stray mult_start then
    task automatic do_op(input bit is_mul, input bit is_div, input logic [31:0] ta,
                         input logic [31:0] tb_v, input int inject_at, input string tag);
        logic [63:0] res;
        int          lat;
        res = is_mul ? ref_mul(ta, tb_v) : ref_div(ta, tb_v);
        lat = is_mul ? 33 : 34;
        @(negedge clk);
        mult_start = is_mul;
        div_start  = is_div;
        a          = ta;
        b          = tb_v;
        @(posedge clk); #1;
        check({tag, " st c0"}, status(), 64'h0);
        mult_start = 1'b0;
        div_start  = 1'b0;
        a          = $urandom;
        b          = $urandom;
        for (int c = 1; c <= lat; c++) begin
            if (c == inject_at) begin
                mult_start = 1'b1;
                a          = $urandom;
                b          = $urandom;
            end
            @(posedge clk); #1;
            mult_start = 1'b0;
            if (c < lat) begin
                check($sformatf("%s st c%0d", tag, c), status(), 64'h10);
            end else begin
                check($sformatf("%s st c%0d", tag, c), status(), 64'h1E);
                check({tag, " hilo"}, {hi, lo}, res);
            end
        end
        exp_hi = res[63:32];
        exp_lo = res[31:0];
        @(posedge clk); #1;
        check({tag, " st after"}, status(), 64'h0);
        check({tag, " hold"}, {hi, lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        reset      = 1'b1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        a          = 32'h0;
        b          = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset st", status(), 64'h0);
        check("reset hilo", {hi, lo}, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        do_op(1'b1, 1'b0, 32'h00000007, 32'hFFFFFFFD, 0, "mul 7*-3");
        do_op(1'b1, 1'b0, 32'h80000000, 32'h80000000, 0, "mul minmin");
        do_op(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "mul -1*-1");
        do_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'h00000002, 0, "div -7/2");
        do_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 0, "div min/-1");
        do_op(1'b0, 1'b1, 32'h00000451, 32'h00000020, 0, "div 11/22");

        // Divide by zero leaves hi/lo at 0x11/0x22 and raises divzero one cycle late
        @(negedge clk);
        div_start = 1'b1;
        a         = 32'h5;
        b         = 32'h0;
        @(posedge clk); #1;
        div_start = 1'b0;
        check("dz c0", status(), 64'h0);
        @(posedge clk); #1;
        check("dz c1", status(), 64'h01);
        check("dz hold", {hi, lo}, {32'h11, 32'h22});
        @(posedge clk); #1;
        check("dz c2", status(), 64'h0);

        do_op(1'b0, 1'b1, 32'hDEADBEEF, 32'h00001234, 5, "div inj");

        // Reset after ten multiply iterations aborts without any strobe
        @(negedge clk);
        mult_start = 1'b1;
        a          = $urandom;
        b          = $urandom;
        @(posedge clk); #1;
        mult_start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst mid st", status(), 64'h0);
        check("rst mid hilo", {hi, lo}, 64'h0);
        exp_hi = 32'h0;
        exp_lo = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("post rst st%0d", i), status(), 64'h0);
        end
        do_op(1'b1, 1'b0, 32'h3, 32'h4, 0, "mul 3*4");
        do_op(1'b1, 1'b1, 32'h6, 32'h0, 0, "both b0");

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            do_op(1'b1, 1'b0, ra, rb, 0, $sformatf("rmul%0d", i));
        end
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = (i < 3) ? $urandom : {{16{ra[0]}}, 16'($urandom)};
            if (rb == 32'h0) begin
                rb = 32'h1;
            end
            do_op(1'b0, 1'b1, ra, rb, 0, $sformatf("rdiv%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
